up_down_counter_n: RTL and testbench
====================================

UP_DOWN_COUNTER_N -- requirements
Module: up_down_counter_n

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal 2..32.
REQ-002 Parameter MAX_COUNT, default 2**WIDTH-1: terminal count; count range is 0..MAX_COUNT, legal 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the range ends, 1 = hold at the range ends.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-005 clk  input  1  sole clock, rising-edge active.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 clr  input  1  synchronous clear of count and flags.
REQ-008 load  input  1  parallel load strobe.
REQ-009 load_val  input  WIDTH  value for a parallel load.
REQ-010 en  input  1  count enable.
REQ-011 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-012 q  output  WIDTH  registered count.
REQ-013 tc  output  1  combinational terminal-count or carry, for cascading.
REQ-014 zero  output  1  registered flag, high when q == 0.
REQ-015 ovf  output  1  registered sticky over/underflow flag.

Function
REQ-016 All state SHALL update only on the rising edge of clk, with this priority: rst_n low, then clr, then load, then en; otherwise q holds.
REQ-017 clr high SHALL set q=0 and ovf=0 on the next edge.
REQ-018 A load SHALL set q=load_val on the next edge; any load_val > MAX_COUNT SHALL be clamped to MAX_COUNT; a load SHALL NOT change ovf.
REQ-019 en=1, up_dn=1, q<MAX_COUNT SHALL give q+1 on the next edge; en=1, up_dn=0, q>0 SHALL give q-1.
REQ-020 Up-count at q==MAX_COUNT SHALL give q=0 when SATURATE=0 and hold MAX_COUNT when SATURATE=1; in both cases ovf SHALL be set on the same edge.
REQ-021 Down-count at q==0 SHALL give q=MAX_COUNT when SATURATE=0 and hold 0 when SATURATE=1; in both cases ovf SHALL be set on the same edge.
REQ-022 tc SHALL equal en & ~clr & ~load & ((up_dn & q==MAX_COUNT) | (~up_dn & q==0)), with zero-cycle latency.
REQ-023 zero SHALL be registered, coherent with q every cycle, and never lag q.
REQ-024 ovf SHALL remain set until rst_n or clr; clr and a wrap in the same cycle SHALL leave ovf=0.
REQ-025 A direction change with en=1 SHALL take effect on the same edge, with no dead cycle.
REQ-026 Simultaneous load and en SHALL perform the load only; no count and no ovf update.
REQ-027 Arithmetic SHALL be WIDTH bits; no intermediate value outside 0..MAX_COUNT shall ever appear on q.

Reset
REQ-028 rst_n low at a rising edge SHALL set q=0, zero=1 and ovf=0, overriding all other inputs.
REQ-029 Reset asserted mid-count SHALL abort the count on that edge; counting SHALL resume from 0 on the first edge with rst_n high and en=1.
REQ-030 Outputs are undefined before the first reset edge; no asynchronous path from rst_n SHALL exist.

Structure
REQ-031 The shared package counter_pkg SHALL hold the direction constants CNT_UP and CNT_DN and a function computing the default MAX_COUNT from WIDTH.
REQ-032 A sub-module, counter_next_calc, SHALL hold the combinational next-count, tc and ovf-event logic; it SHALL be instantiated once, with the register stage in the top module.
REQ-033 Two instances SHALL cascade cleanly: the upper instance's en driven from the lower instance's tc.

Verification (WIDTH=4, MAX_COUNT=9 unless stated)
REQ-034 Reset then en=1, up_dn=1 for 12 cycles -> q goes 0..9,0,1; tc high at q=9; ovf set on the 9->0 edge.
REQ-035 SATURATE=1, load 2, up_dn=0, en=1 for 4 cycles -> q 2,1,0,0,0; ovf set on the edge where q holds at 0; zero high from the q=0 cycle.
REQ-036 load_val=15 with load=1 and en=1 -> q=9 (clamped), ovf unchanged, no count that cycle.
REQ-037 Count up to 5, then rst_n=0 with en=1, load=1, clr=1 -> q=0, ovf=0, zero=1 next edge; resumes 1 after rst_n returns high.
REQ-038 Two cascaded instances of WIDTH=4 with default MAX_COUNT -> count 0..255 in 256 cycles; upper increments only on the lower 15->0 wrap.
REQ-039 ovf set, then clr and a wrap in the same cycle -> q=0, ovf=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
// Direction encodings and the default terminal count for a given width.
package counter_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // All-ones value for a WIDTH-bit counter. The shift is done in 64 bits so
    // that WIDTH=32 does not overflow.
    function automatic logic [31:0] default_max_count(input int unsigned width);
        logic [63:0] w_full;
        w_full = (64'd1 << width) - 64'd1;
        return w_full[31:0];
    endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count, terminal-count and over/underflow-event logic
// for up_down_counter_n. Priority is clr, then load, then count enable.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_Q   = '1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_up_dn,
    output logic [WIDTH-1:0] o_next_q,
    output logic             o_tc,
    output logic             o_ovf_evt
);

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_at_end;
    logic             w_count_active;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_wrap_up;
    logic [WIDTH-1:0] w_wrap_dn;

    assign w_at_max       = (i_q == MAX_Q);
    assign w_at_zero      = (i_q == '0);
    assign w_at_end       = (i_up_dn == CNT_UP) ? w_at_max : w_at_zero;
    assign w_count_active = i_en & ~i_clr & ~i_load;

    // The carry and the sticky-flag event are the same condition: a real
    // count step attempted at the end of the range in the current direction.
    assign o_tc      = w_count_active & w_at_end;
    assign o_ovf_evt = o_tc;

    assign w_load_clamped = (i_load_val > MAX_Q) ? MAX_Q : i_load_val;
    assign w_wrap_up      = SATURATE ? MAX_Q : '0;
    assign w_wrap_dn      = SATURATE ? '0 : MAX_Q;

    always_comb begin
        o_next_q = i_q;
        if (i_clr) begin
            o_next_q = '0;
        end else if (i_load) begin
            o_next_q = w_load_clamped;
        end else if (i_en) begin
            if (i_up_dn == CNT_UP) begin
                o_next_q = w_at_max ? w_wrap_up : (i_q + WIDTH'(1));
            end else begin
                o_next_q = w_at_zero ? w_wrap_dn : (i_q - WIDTH'(1));
            end
        end
    end

endmodule

// File: rtl/up_down_counter_n.sv
// Parameterised up/down counter with clamped parallel load, wrap or saturate
// at the range ends, registered zero flag and sticky over/underflow flag.
module up_down_counter_n
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter logic [31:0] MAX_COUNT = default_max_count(WIDTH),
    parameter bit          SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q = MAX_COUNT[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    logic             r_zero;
    logic             r_ovf;

    logic [WIDTH-1:0] w_next_q;
    logic             w_tc;
    logic             w_ovf_evt;

    counter_next_calc #(
        .WIDTH    (WIDTH),
        .MAX_Q    (MAX_Q),
        .SATURATE (SATURATE)
    ) u_next (
        .i_q        (r_q),
        .i_clr      (clr),
        .i_load     (load),
        .i_load_val (load_val),
        .i_en       (en),
        .i_up_dn    (up_dn),
        .o_next_q   (w_next_q),
        .o_tc       (w_tc),
        .o_ovf_evt  (w_ovf_evt)
    );

    // zero is derived from the next count so it changes on the same edge as q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_zero <= 1'b1;
            r_ovf  <= 1'b0;
        end else begin
            r_q    <= w_next_q;
            r_zero <= (w_next_q == '0);
            r_ovf  <= clr ? 1'b0 : (r_ovf | w_ovf_evt);
        end
    end

    assign q    = r_q;
    assign zero = r_zero;
    assign ovf  = r_ovf;
    assign tc   = w_tc;

endmodule

// File: tb/tb_up_down_counter_n.sv
// Scoreboard bench: stimulus pushes hand-computed expectations per edge, an
// independent monitor pops and compares after each rising edge.
module tb_up_down_counter_n;

    typedef struct {
        int         tid;
        int         sel;
        logic [7:0] q;
        logic       zero;
        logic       ovf;
        logic       tc;
        bit         chk_tc;
        bit         chk_flags;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tid_cnt = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: WIDTH=4, MAX_COUNT=9, wrap
    logic       rst_n0 = 1'b0, clr0 = 1'b0, load0 = 1'b0, en0 = 1'b0, up0 = 1'b1;
    logic [3:0] lv0 = 4'd0;
    logic [3:0] q0;
    logic       tc0, zero0, ovf0;

    // DUT 1: WIDTH=4, MAX_COUNT=9, saturate
    logic       rst_n1 = 1'b0, clr1 = 1'b0, load1 = 1'b0, en1 = 1'b0, up1 = 1'b1;
    logic [3:0] lv1 = 4'd0;
    logic [3:0] q1;
    logic       tc1, zero1, ovf1;

    // Cascade: two WIDTH=4 default-range counters
    logic       rst_nc = 1'b0, enc = 1'b0;
    logic [3:0] ql, qh;
    logic       tcl, tch, zerol, zeroh, ovfl, ovfh;

    up_down_counter_n #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n0), .clr(clr0), .load(load0), .load_val(lv0),
        .en(en0), .up_dn(up0), .q(q0), .tc(tc0), .zero(zero0), .ovf(ovf0));

    up_down_counter_n #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .clr(clr1), .load(load1), .load_val(lv1),
        .en(en1), .up_dn(up1), .q(q1), .tc(tc1), .zero(zero1), .ovf(ovf1));

    up_down_counter_n #(.WIDTH(4)) dut_lo (
        .clk(clk), .rst_n(rst_nc), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .en(enc), .up_dn(1'b1), .q(ql), .tc(tcl), .zero(zerol), .ovf(ovfl));

    up_down_counter_n #(.WIDTH(4)) dut_hi (
        .clk(clk), .rst_n(rst_nc), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .en(tcl), .up_dn(1'b1), .q(qh), .tc(tch), .zero(zeroh), .ovf(ovfh));

    task automatic push_exp(input int sel, input logic [7:0] eq, input bit ez, eo, et,
                            input bit ct, input bit cf);
        exp_t e;
        e.tid = tid_cnt; e.sel = sel; e.q = eq; e.zero = ez; e.ovf = eo;
        e.tc = et; e.chk_tc = ct; e.chk_flags = cf;
        tid_cnt++;
        exp_q.push_back(e);
    endtask

    // One edge of DUT 0 or DUT 1: drive inputs at the falling edge, expect the
    // given state after the next rising edge and the given tc before it.
    task automatic step(input int sel, input bit rst, c, l, input logic [3:0] lv,
                        input bit e, u, input logic [3:0] eq, input bit ez, eo, et,
                        input bit ct);
        @(negedge clk);
        if (sel == 0) begin
            rst_n0 = rst; clr0 = c; load0 = l; lv0 = lv; en0 = e; up0 = u;
        end else begin
            rst_n1 = rst; clr1 = c; load1 = l; lv1 = lv; en1 = e; up1 = u;
        end
        push_exp(sel, {4'd0, eq}, ez, eo, et, ct, 1'b1);
    endtask

    task automatic casc_step(input bit rst, e, input logic [7:0] eq, input bit et,
                             input bit ct);
        @(negedge clk);
        rst_nc = rst; enc = e;
        push_exp(2, eq, 1'b0, 1'b0, et, ct, 1'b0);
    endtask

    task automatic check(input string nm, input int tid, input logic [31:0] act,
                         input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s txn %0d: got %0h, expected %0h", nm, tid, act, expv);
        end
    endtask

    // Monitor: snapshot tc once inputs have settled, then compare the
    // registered state just after the rising edge.
    initial begin : monitor
        logic       tc_s0, tc_s1, tc_sc;
        logic [7:0] act_q;
        logic       act_z, act_o, act_t;
        exp_t       e;
        forever begin
            @(negedge clk);
            #2;
            tc_s0 = tc0; tc_s1 = tc1; tc_sc = tcl;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.sel)
                    0:       begin act_q = {4'd0, q0}; act_z = zero0; act_o = ovf0; act_t = tc_s0; end
                    1:       begin act_q = {4'd0, q1}; act_z = zero1; act_o = ovf1; act_t = tc_s1; end
                    default: begin act_q = {qh, ql};   act_z = 1'b0;  act_o = 1'b0; act_t = tc_sc; end
                endcase
                check("q", e.tid, 32'(act_q), 32'(e.q));
                if (e.chk_flags) begin
                    check("zero", e.tid, 32'(act_z), 32'(e.zero));
                    check("ovf", e.tid, 32'(act_o), 32'(e.ovf));
                end
                if (e.chk_tc) check("tc", e.tid, 32'(act_t), 32'(e.tc));
                $display("txn %0d dut=%0d q=%0h zero=%0b ovf=%0b tc=%0b", e.tid, e.sel,
                         act_q, act_z, act_o, act_t);
            end
        end
    end

    initial begin : stimulus
        // Wrapping counter: reset, then 12 up counts crossing 9->0
        step(0, 0, 0, 0, 4'd0, 0, 1, 4'd0, 1, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0, 0, 4'd0, 1, 1, 4'((k + 1) % 10), ((k + 1) % 10) == 0,
                 k >= 9, (k % 10) == 9, 1);
        end
        // Load 9, then clear and wrap together: ovf must end up cleared
        step(0, 1, 0, 1, 4'd9, 0, 1, 4'd9, 0, 1, 0, 1);
        step(0, 1, 1, 0, 4'd0, 1, 1, 4'd0, 1, 0, 0, 1);
        // Underflow 0 -> 9 sets ovf
        step(0, 1, 0, 0, 4'd0, 1, 0, 4'd9, 0, 1, 1, 1);
        // Load 15 with en: clamped to 9, no count, ovf kept
        step(0, 1, 0, 1, 4'd15, 1, 1, 4'd9, 0, 1, 0, 1);
        // Direction changes every edge with no dead cycle
        step(0, 1, 0, 0, 4'd0, 1, 1, 4'd0, 1, 1, 1, 1);
        step(0, 1, 0, 0, 4'd0, 1, 0, 4'd9, 0, 1, 1, 1);
        step(0, 1, 0, 0, 4'd0, 1, 1, 4'd0, 1, 1, 1, 1);
        // Hold with en low, then clear
        step(0, 1, 0, 0, 4'd0, 0, 1, 4'd0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 4'd0, 0, 1, 4'd0, 1, 0, 0, 1);
        // Count to 5, then reset against every other input, then resume
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0, 4'd0, 1, 1, 4'(k + 1), 0, 0, 0, 1);
        end
        step(0, 0, 1, 1, 4'd7, 1, 1, 4'd0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, 0, 1);
        step(0, 1, 0, 1, 4'd4, 0, 1, 4'd4, 0, 0, 0, 1);
        step(0, 1, 0, 0, 4'd0, 1, 0, 4'd3, 0, 0, 0, 1);

        // Saturating counter: load 2, count down into and past 0
        step(1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 4'd2, 0, 0, 4'd2, 0, 0, 0, 1);
        step(1, 1, 0, 0, 4'd0, 1, 0, 4'd1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 4'd0, 1, 0, 4'd0, 1, 1, 1, 1);
        step(1, 1, 0, 0, 4'd0, 1, 0, 4'd0, 1, 1, 1, 1);
        // Load 10 clamps to 9; up holds at 9 with tc; down leaves the end
        step(1, 1, 0, 1, 4'd10, 0, 1, 4'd9, 0, 1, 0, 1);
        step(1, 1, 0, 0, 4'd0, 1, 1, 4'd9, 0, 1, 1, 1);
        step(1, 1, 0, 0, 4'd0, 1, 0, 4'd8, 0, 1, 0, 1);

        // Cascade: 8-bit count through a full 256 cycle plus the rollover
        casc_step(0, 0, 8'd0, 0, 0);
        for (int k = 0; k < 257; k++) begin
            casc_step(1, 1, 8'((k + 1) % 256), (k % 16) == 15, 1);
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
